// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: multi-port register file with write bypass, pending scoreboard
// and a zeroing init sequencer that clears one entry per cycle after reset.
module regfile_mp_scoreboard #(
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_SEL_BITS = 5,
  parameter int READ_PORTS = 2,
  parameter int BYPASS = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  output logic                                 ready,
  input  logic [READ_PORTS*REG_SEL_BITS-1:0]   read_sel,
  output logic [READ_PORTS*REG_DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]                read_busy,
  input  logic                                 wEn,
  input  logic [REG_SEL_BITS-1:0]              write_sel,
  input  logic [REG_DATA_WIDTH-1:0]            write_data,
  input  logic                                 reserve_en,
  input  logic [REG_SEL_BITS-1:0]              reserve_sel
);
  localparam int DEPTH = 1 << REG_SEL_BITS;
  localparam logic [REG_SEL_BITS:0] LAST = (REG_SEL_BITS + 1)'(DEPTH - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_next;
  logic [REG_SEL_BITS:0] cnt;
  logic [REG_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic run, wr_ok, rsv_ok, mem_we;
  logic [REG_SEL_BITS-1:0] mem_addr;
  logic [REG_DATA_WIDTH-1:0] mem_wdata;
  always_comb begin
    state_next = state;
    if (state == INIT && cnt == LAST) state_next = RUN;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end
  assign ready = state == RUN;
  assign run = ready & reset;
  assign wr_ok = run & wEn & (write_sel != '0);
  assign rsv_ok = run & reserve_en & (reserve_sel != '0);
  // Single write port shared by the init sequencer and writeback keeps the array RAM-inferable
  assign mem_we = (state == INIT) | wr_ok;
  assign mem_addr = (state == INIT) ? cnt[REG_SEL_BITS-1:0] : write_sel;
  assign mem_wdata = (state == INIT) ? '0 : write_data;
  always_ff @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;
  // The reserve assignment comes last so a new producer wins over a same-index write
  always_ff @(posedge clock) begin
    if (!reset) pending <= '0;
    else begin
      if (wr_ok) pending[write_sel] <= 1'b0;
      if (rsv_ok) pending[reserve_sel] <= 1'b1;
    end
  end
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [REG_SEL_BITS-1:0] sel;
    logic hit;
    assign sel = read_sel[p*REG_SEL_BITS +: REG_SEL_BITS];
    assign hit = (BYPASS != 0) && wr_ok && (write_sel == sel);
    assign read_data[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] = (!run || sel == '0) ? '0 : hit ? write_data : mem[sel];
    assign read_busy[p] = run && (sel != '0) && !hit && pending[sel];
  end
endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb_regfile_mp_scoreboard: directed and randomized checks of the register file against an array model,
// covering bypass and non-bypass builds plus a narrow four-port build.
module tb_regfile_mp_scoreboard;
  logic clock = 0;
  always #5 clock = ~clock;
  logic reset = 0, wEn = 0, reserve_en = 0;
  logic [4:0] write_sel = 0, reserve_sel = 0;
  logic [31:0] write_data = 0;
  logic [9:0] read_sel = 0;
  logic ready0, ready1, ready2;
  logic [63:0] rd0, rd1, rd2;
  logic [1:0] rb0, rb1;
  logic [3:0] rb2;
  logic w2en = 0;
  logic [2:0] w2sel = 0;
  logic [15:0] w2data = 0;
  logic [11:0] rs2 = 0;
  regfile_mp_scoreboard #(.BYPASS(1)) u0 (
    .clock(clock), .reset(reset), .ready(ready0), .read_sel(read_sel), .read_data(rd0), .read_busy(rb0),
    .wEn(wEn), .write_sel(write_sel), .write_data(write_data), .reserve_en(reserve_en), .reserve_sel(reserve_sel));
  regfile_mp_scoreboard #(.BYPASS(0)) u1 (
    .clock(clock), .reset(reset), .ready(ready1), .read_sel(read_sel), .read_data(rd1), .read_busy(rb1),
    .wEn(wEn), .write_sel(write_sel), .write_data(write_data), .reserve_en(reserve_en), .reserve_sel(reserve_sel));
  regfile_mp_scoreboard #(.REG_DATA_WIDTH(16), .REG_SEL_BITS(3), .READ_PORTS(4), .BYPASS(1)) u2 (
    .clock(clock), .reset(reset), .ready(ready2), .read_sel(rs2), .read_data(rd2), .read_busy(rb2),
    .wEn(w2en), .write_sel(w2sel), .write_data(w2data), .reserve_en(1'b0), .reserve_sel(3'd0));
  logic [31:0] m_mem [32];
  logic [31:0] m_pend = '0;
  logic [15:0] m2_mem [8];
  int since = 0;
  int checks = 0, errors = 0;
  function automatic logic [31:0] exp_data(input logic [4:0] sel, input bit byp);
    if (since < 32 || !reset || sel == 0) return 32'h0;
    if (byp && wEn && write_sel == sel) return write_data;
    return m_mem[sel];
  endfunction
  function automatic logic exp_busy(input logic [4:0] sel, input bit byp);
    if (since < 32 || !reset || sel == 0) return 1'b0;
    if (byp && wEn && write_sel == sel) return 1'b0;
    return m_pend[sel];
  endfunction
  task automatic step();
    @(posedge clock);
    if (!reset) begin
      since = 0;
      m_pend = '0;
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      for (int i = 0; i < 8; i++) m2_mem[i] = '0;
    end else begin
      if (since >= 32) begin
        if (wEn && write_sel != 0) begin
          m_mem[write_sel] = write_data;
          m_pend[write_sel] = 1'b0;
        end
        if (reserve_en && reserve_sel != 0) m_pend[reserve_sel] = 1'b1;
      end
      if (since >= 8 && w2en && w2sel != 0) m2_mem[w2sel] = w2data;
      since++;
    end
    @(negedge clock);
  endtask
  task automatic test_reset();
    reset = 0;
    repeat (3) step();
    reset = 1;
    for (int k = 1; k <= 33; k++) begin
      #1;
      checks++;
      if (ready0 !== (k == 33) || ready1 !== (k == 33)) begin
        errors++;
        $display("FAIL reset_ready cycle %0d got %b/%b exp %b", k, ready0, ready1, k == 33);
      end
      checks++;
      if (ready2 !== (k >= 9)) begin
        errors++;
        $display("FAIL reset_ready_narrow cycle %0d got %b exp %b", k, ready2, k >= 9);
      end
      if (k < 33) begin
        read_sel = {5'(k % 32), 5'(k % 32)};
        checks++;
        if (rd0 !== 64'h0 || rb0 !== 2'b00) begin
          errors++;
          $display("FAIL init_outputs cycle %0d got %h/%b exp 0/00", k, rd0, rb0);
        end
        step();
      end
    end
    for (int i = 0; i < 32; i++) begin
      read_sel = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (rd0 !== 64'h0 || rd1 !== 64'h0 || rb0 !== 2'b00 || rb1 !== 2'b00) begin
        errors++;
        $display("FAIL reset_zero idx %0d got %h %h %b %b exp 0", i, rd0, rd1, rb0, rb1);
      end
    end
  endtask
  task automatic test_write();
    wEn = 1; write_sel = 5; write_data = 32'hDEADBEEF;
    step();
    wEn = 0; read_sel = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd0 !== {2{32'hDEADBEEF}} || rd1 !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL write_x5 got %h %h exp %h", rd0, rd1, {2{32'hDEADBEEF}});
    end
    wEn = 1; write_sel = 0; write_data = 32'h12345678; read_sel = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd0 !== 64'h0 || rb0 !== 2'b00) begin
      errors++;
      $display("FAIL write_x0_bypass got %h %b exp 0", rd0, rb0);
    end
    step();
    wEn = 0;
    #1;
    checks++;
    if (rd0 !== 64'h0 || rd1 !== 64'h0) begin
      errors++;
      $display("FAIL write_x0 got %h %h exp 0", rd0, rd1);
    end
  endtask
  task automatic test_bypass();
    reserve_en = 1; reserve_sel = 7;
    step();
    reserve_en = 0;
    wEn = 1; write_sel = 7; write_data = 32'hA5A5A5A5; read_sel = {5'd7, 5'd5};
    #1;
    checks++;
    if (rd0[63:32] !== 32'hA5A5A5A5 || rb0[1] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_on got %h busy %b exp a5a5a5a5 busy 0", rd0[63:32], rb0[1]);
    end
    checks++;
    if (rd1[63:32] !== 32'h0 || rb1[1] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_off got %h busy %b exp 00000000 busy 1", rd1[63:32], rb1[1]);
    end
    checks++;
    if (rd0[31:0] !== 32'hDEADBEEF || rd1[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_other_port got %h %h exp deadbeef", rd0[31:0], rd1[31:0]);
    end
    step();
    wEn = 0;
    #1;
    checks++;
    if (rd1[63:32] !== 32'hA5A5A5A5 || rb1[1] !== 1'b0 || rb0[1] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_next got %h busy %b/%b exp a5a5a5a5 busy 0", rd1[63:32], rb0[1], rb1[1]);
    end
  endtask
  task automatic test_scoreboard();
    read_sel = {5'd9, 5'd9};
    reserve_en = 1; reserve_sel = 9;
    #1;
    checks++;
    if (rb0 !== 2'b00) begin
      errors++;
      $display("FAIL reserve_same_cycle got %b exp 00", rb0);
    end
    step();
    reserve_en = 0;
    #1;
    checks++;
    if (rb0 !== 2'b11 || rb1 !== 2'b11) begin
      errors++;
      $display("FAIL reserve_x9 got %b %b exp 11", rb0, rb1);
    end
    wEn = 1; write_sel = 9; write_data = 32'h11111111;
    #1;
    checks++;
    if (rb1 !== 2'b11 || rb0 !== 2'b00) begin
      errors++;
      $display("FAIL write_busy_comb got %b %b exp 00 11", rb0, rb1);
    end
    step();
    wEn = 0;
    #1;
    checks++;
    if (rb0 !== 2'b00 || rb1 !== 2'b00) begin
      errors++;
      $display("FAIL write_clears got %b %b exp 00", rb0, rb1);
    end
    wEn = 1; write_sel = 9; write_data = 32'h22222222; reserve_en = 1; reserve_sel = 9;
    step();
    wEn = 0; reserve_en = 0;
    #1;
    checks++;
    if (rb0 !== 2'b11 || rd0 !== {2{32'h22222222}}) begin
      errors++;
      $display("FAIL reserve_wins got %b %h exp 11 %h", rb0, rd0, {2{32'h22222222}});
    end
    wEn = 1; write_sel = 9; write_data = 32'h33333333; reserve_en = 1; reserve_sel = 10;
    step();
    wEn = 0; reserve_en = 0; read_sel = {5'd10, 5'd9};
    #1;
    checks++;
    if (rb0 !== 2'b10 || rd1[31:0] !== 32'h33333333) begin
      errors++;
      $display("FAIL write_reserve_split got %b %h exp 10 33333333", rb0, rd1[31:0]);
    end
    reserve_en = 1; reserve_sel = 10;
    step();
    reserve_en = 0;
    #1;
    checks++;
    if (rb1 !== 2'b10) begin
      errors++;
      $display("FAIL re_reserve got %b exp 10", rb1);
    end
  endtask
  task automatic test_wide();
    for (int i = 1; i <= 4; i++) begin
      w2en = 1; w2sel = 3'(i); w2data = 16'(i);
      step();
    end
    w2en = 0; rs2 = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd2[p*16 +: 16] !== 16'(p + 1) || rb2[p] !== 1'b0) begin
        errors++;
        $display("FAIL wide_port %0d got %h busy %b exp %h busy 0", p, rd2[p*16 +: 16], rb2[p], 16'(p + 1));
      end
    end
    rs2 = {3'd1, 3'd2, 3'd0, 3'd2};
    w2en = 1; w2sel = 2; w2data = 16'hBEEF;
    #1;
    checks++;
    if (rd2 !== {16'h0001, 16'hBEEF, 16'h0000, 16'hBEEF}) begin
      errors++;
      $display("FAIL wide_bypass got %h exp 0001beef0000beef", rd2);
    end
    step();
    w2en = 0;
    #1;
    checks++;
    if (rd2[15:0] !== m2_mem[2] || rd2[15:0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wide_stored got %h exp beef", rd2[15:0]);
    end
  endtask
  task automatic test_random();
    logic [4:0] s;
    for (int n = 0; n < 400; n++) begin
      wEn = 1'($urandom);
      write_sel = 5'($urandom_range(0, 7));
      write_data = $urandom;
      reserve_en = ($urandom % 3) == 0;
      reserve_sel = 5'($urandom_range(0, 7));
      read_sel = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int p = 0; p < 2; p++) begin
        s = read_sel[p*5 +: 5];
        checks++;
        if (rd0[p*32 +: 32] !== exp_data(s, 1) || rb0[p] !== exp_busy(s, 1)) begin
          errors++;
          $display("FAIL rand_bypass n %0d port %0d sel %0d got %h/%b exp %h/%b", n, p, s, rd0[p*32 +: 32], rb0[p], exp_data(s, 1), exp_busy(s, 1));
        end
        checks++;
        if (rd1[p*32 +: 32] !== exp_data(s, 0) || rb1[p] !== exp_busy(s, 0)) begin
          errors++;
          $display("FAIL rand_nobypass n %0d port %0d sel %0d got %h/%b exp %h/%b", n, p, s, rd1[p*32 +: 32], rb1[p], exp_data(s, 0), exp_busy(s, 0));
        end
      end
      step();
    end
    wEn = 0; reserve_en = 0;
  endtask
  task automatic test_reset_mid();
    reset = 0;
    step();
    reset = 1;
    repeat (10) step();
    reset = 0;
    step();
    reset = 1;
    for (int k = 1; k <= 33; k++) begin
      wEn = (k == 5); write_sel = 3; write_data = 32'hFFFFFFFF;
      reserve_en = (k == 5); reserve_sel = 4;
      w2en = (k == 5); w2sel = 3; w2data = 16'hFFFF;
      #1;
      checks++;
      if (ready0 !== (k == 33) || ready1 !== (k == 33)) begin
        errors++;
        $display("FAIL midreset_ready cycle %0d got %b/%b exp %b", k, ready0, ready1, k == 33);
      end
      if (k < 33) step();
    end
    wEn = 0; reserve_en = 0; w2en = 0;
    for (int i = 0; i < 32; i++) begin
      read_sel = {5'(i), 5'(i)};
      #1;
      checks++;
      if (rd0 !== 64'h0 || rd1 !== 64'h0 || rb0 !== 2'b00 || rb1 !== 2'b00) begin
        errors++;
        $display("FAIL midreset_zero idx %0d got %h %h %b %b exp 0", i, rd0, rd1, rb0, rb1);
      end
    end
    rs2 = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    checks++;
    if (rd2 !== 64'h0) begin
      errors++;
      $display("FAIL midreset_wide got %h exp 0", rd2);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    @(negedge clock);
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_wide();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the core's integer register file. It adds a configurable number of combinational read ports, optional write-to-read bypass, and a per-register pending (scoreboard) bit for hazard detection in the pipelined core. An initialisation sequencer zeroes every entry after reset, one entry per cycle, so the storage remains distributed-RAM friendly. The block sits in decode: read ports feed operand fetch, the write port is driven by writeback, and the reserve port is driven by issue.

Parameters:
- REG_DATA_WIDTH, 32, width of each register.
- REG_SEL_BITS, 5, register index width; depth is 2^REG_SEL_BITS.
- READ_PORTS, 2, number of independent read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (sampled on the rising clock edge, 0 = reset).
- ready  output  1  high once initialisation is complete.
- read_sel  input  READ_PORTS*REG_SEL_BITS  packed read indices; port p uses bits [p*REG_SEL_BITS +: REG_SEL_BITS].
- read_data  output  READ_PORTS*REG_DATA_WIDTH  packed read data, same packing as read_sel.
- read_busy  output  READ_PORTS  pending bit of each port's selected register.
- wEn  input  1  write enable.
- write_sel  input  REG_SEL_BITS  write index.
- write_data  input  REG_DATA_WIDTH  write data.
- reserve_en  input  1  mark a register pending.
- reserve_sel  input  REG_SEL_BITS  index to reserve.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM enters INIT, init counter = 0, ready = 0.
  - All pending bits are cleared in the same cycle.
  - Outputs during reset/INIT: read_data = 0, read_busy = 0.
- FSM INIT:
  - Each cycle writes 0 to entry[counter], then counter += 1.
  - When counter == 2^REG_SEL_BITS-1 is written, the next state is RUN.
  - ready rises the cycle after the last entry is written, i.e. exactly 2^REG_SEL_BITS cycles after reset deasserts.
  - wEn and reserve_en are ignored in INIT.
- FSM RUN:
  - Stays in RUN until the next reset. Reset asserted mid-INIT restarts the counter at 0.
- Reads:
  - Combinational from read_sel.
  - Index 0 always returns 0 and busy 0.
  - If BYPASS==1, wEn==1, write_sel==read_sel[p] and write_sel!=0, read_data[p] = write_data in the same cycle.
  - If BYPASS==0, the read returns the old value; the new value is visible from the next cycle.
- Writes:
  - In RUN, wEn==1 and write_sel!=0 writes entry[write_sel] at the clock edge.
  - A write clears pending[write_sel].
  - Writes to index 0 are dropped.
- Scoreboard:
  - In RUN, reserve_en==1 and reserve_sel!=0 sets pending[reserve_sel] at the clock edge.
  - Simultaneous write and reserve to the same index: set wins and the register stays pending (new producer).
  - Simultaneous write and reserve to different indices: both take effect.
  - Reserving an already-pending register keeps it pending.
  - read_busy[p] = pending[read_sel[p]], registered state only. A same-cycle write does not clear the busy output combinationally unless BYPASS==1, in which case read_busy[p] = 0 for the bypassed port.
- Multiple read ports selecting the same index return identical data and busy.
- No arithmetic on data; the init counter is REG_SEL_BITS+1 bits wide to detect completion without wrap-around.

Test Plan:
1. Reset held low for 3 cycles, then released. ready must be 0 for exactly 32 cycles and 1 on cycle 33. Reading all 32 indices afterwards returns 0x00000000, with read_busy all 0.
2. In RUN, write 0xDEADBEEF to x5 (wEn=1). Next cycle, read_sel port0=5, port1=5: both ports return 0xDEADBEEF. Writing 0x12345678 to x0 leaves x0 reading 0.
3. BYPASS=1: wEn=1, write_sel=7, write_data=0xA5A5A5A5 with port1 reading 7 in the same cycle: read_data[1]=0xA5A5A5A5 and read_busy[1]=0 that cycle. Repeat with BYPASS=0: the old value is returned that cycle and the new value the next.
4. reserve x9: read_busy=1 on x9 from the next cycle. A write to x9 clears busy the cycle after. A simultaneous reserve and write to x9 leaves busy=1 and stores the data.
5. Assert reset at INIT counter=10, hold for 1 cycle: ready stays 0 for a further full 32 cycles. A wEn/reserve_en pulse issued during INIT has no effect: all entries read 0 and all busy bits are 0 afterwards.
6. READ_PORTS=4, REG_SEL_BITS=3, REG_DATA_WIDTH=16: init takes 8 cycles. Four ports reading distinct registers x1..x4 (written 0x0001..0x0004) return their values correctly, with correct packed-bus slicing.
